l1_sram_burst_reader: RTL and testbench

//  Read-side DMA for the L1 256x32b dual-port SRAM. On a start pulse, reads LEN

---
 rtl/l1_sram_burst_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_l1_sram_burst_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_sram_burst_reader.sv
// Burst reader: L1 SRAM port 0 -> valid/ready stream, first word 2 cycles after start, then 1 word/cycle.
// out_ready low holds the head word and throttles SRAM issue to 2 words ahead; L1_RD_PERF_CNT_EN adds stall_cnt.

// Small generic FIFO with registered storage; DEPTH must be a power of two.
module l1_rd_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic                       pop_vld,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    assign pop_vld = (count_q != '0);
    assign pop     = pop_vld && pop_rdy;
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_vld) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_vld && !pop && (count_q == CW'(DEPTH))));
endmodule

module l1_sram_burst_reader #(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int LW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] burst_len,
    output logic          busy,
    output logic          done,
    output logic          sram_cen,
    output logic [3:0]    sram_wea0,
    output logic [AW-1:0] sram_addr0,
    output logic [DW-1:0] sram_wdata0,
    input  logic [DW-1:0] sram_rdata0,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
`ifdef L1_RD_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    localparam logic [LW-1:0] MAX_LEN = LW'(1 << AW);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] issued_q, issued_d;
    logic          cen_q, cen_d;
    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic          inflight_q, inflight_d;
    logic          inflight_last_q, inflight_last_d;
    logic          done_q, done_d;

    logic [LW-1:0] len_eff;
    logic [1:0]    fifo_cnt;
    logic [1:0]    credits;
    logic          pop;
    logic          issue_ok;

    // The SRAM returns data in the cycle cen is low, so capture is gated purely by inflight.
    l1_rd_fifo #(.W(DW + 1), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (inflight_q),
        .push_dat ({inflight_last_q, sram_rdata0}),
        .pop_rdy  (out_ready),
        .pop_vld  (out_valid),
        .pop_dat  ({out_last, out_data}),
        .count    (fifo_cnt)
    );

    assign len_eff  = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
    assign pop      = out_valid && out_ready;
    assign credits  = fifo_cnt + {1'b0, inflight_q};
    assign issue_ok = (credits < 2'd2) || ((credits == 2'd2) && pop);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        issued_d        = issued_q;
        cen_d           = 1'b1;
        sram_addr_d     = sram_addr_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        addr_d   = base_addr;
                        len_d    = len_eff;
                        issued_d = '0;
                    end
                end
            end
            RUN: begin
                if (issue_ok) begin
                    cen_d           = 1'b0;
                    sram_addr_d     = addr_q;
                    addr_d          = addr_q + 1'b1;
                    issued_d        = issued_q + 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = (issued_q == len_q - 1'b1);
                    if (issued_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            cen_q           <= 1'b1;
            sram_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            cen_q           <= cen_d;
            sram_addr_q     <= sram_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign sram_cen    = cen_q;
    assign sram_addr0  = sram_addr_q;
    assign sram_wea0   = 4'b0000;
    assign sram_wdata0 = '0;

`ifdef L1_RD_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if (busy && out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_l1_sram_burst_reader.sv
// Randomized bench for l1_sram_burst_reader against a word-sequence scoreboard and an SRAM model.
`timescale 1ns/1ps
module tb_l1_sram_burst_reader;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, sram_cen;
    logic [3:0]    sram_wea0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_wdata0, sram_rdata0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
`ifdef L1_RD_PERF_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    logic [DW-1:0] mem [256];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Read data is only meaningful while cen is low; a poison word exposes any other capture.
    assign sram_rdata0 = sram_cen ? 32'hDEAD_BEEF : mem[sram_addr0];

    l1_sram_burst_reader #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .sram_cen    (sram_cen),
        .sram_wea0   (sram_wea0),
        .sram_addr0  (sram_addr0),
        .sram_wdata0 (sram_wdata0),
        .sram_rdata0 (sram_rdata0),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
`ifdef L1_RD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready.
    task automatic run_burst(input logic [7:0] b, input int l, input int mode, input bit poke);
        logic [32:0] exp_q[$];
        logic [32:0] prev_word, exp_w;
        logic [7:0]  exp_addr;
        int lc, k, issued, accepted, last_hs, first_cen, first_valid, budget;
        bit finished, prev_stall, rdy;
        lc = (l > 256) ? 256 : l;
        for (int i = 0; i < lc; i++) begin
            exp_addr = b + 8'(i);
            exp_q.push_back({(i == lc - 1), mem[exp_addr]});
        end
        k = 0; issued = 0; accepted = 0; last_hs = -1; first_cen = -1; first_valid = -1;
        finished = 1'b0; prev_stall = 1'b0; prev_word = '0;
        budget = 6 * lc + 30;
        base_addr = b; burst_len = LW'(l); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && k < budget) begin
            if (k == 0) begin
                n_checks++;
                if (busy !== (lc != 0)) $display("FAIL busy_after_start: got %b expected %b", busy, lc != 0);
                else n_pass++;
            end
            if (done === 1'b1) begin
                n_checks++;
                if (k != last_hs + 1 || accepted != lc)
                    $display("FAIL done_timing: done at cycle %0d after %0d words, expected cycle %0d after %0d words",
                             k, accepted, last_hs + 1, lc);
                else n_pass++;
                finished = 1'b1;
            end else begin
                if (sram_cen === 1'b0) begin
                    exp_addr = b + 8'(issued);
                    if (first_cen < 0) first_cen = k;
                    issued++;
                    n_checks++;
                    if (sram_addr0 !== exp_addr || issued > lc || issued - accepted > 2)
                        $display("FAIL sram_issue: addr %h issued %0d accepted %0d, expected addr %h issued<=%0d lead<=2",
                                 sram_addr0, issued, accepted, exp_addr, lc);
                    else n_pass++;
                end
                if (prev_stall) begin
                    n_checks++;
                    if (out_valid !== 1'b1 || {out_last, out_data} !== prev_word)
                        $display("FAIL stall_hold: valid %b word %h, expected valid 1 word %h",
                                 out_valid, {out_last, out_data}, prev_word);
                    else n_pass++;
                end
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
                out_ready = rdy;
                start = poke && (k == 3);
                if (start) begin
                    base_addr = 8'($urandom);
                    burst_len = 9'd5;
                end
                if (out_valid === 1'b1) begin
                    if (first_valid < 0) first_valid = k;
                    if (rdy) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL extra_word: got %h, expected no further word", {out_last, out_data});
                        end else begin
                            exp_w = exp_q.pop_front();
                            if ({out_last, out_data} !== exp_w)
                                $display("FAIL stream_word %0d: got %h expected %h", accepted, {out_last, out_data}, exp_w);
                            else n_pass++;
                        end
                        accepted++;
                        last_hs = k;
                    end
                end
                prev_stall = (out_valid === 1'b1) && !rdy;
                prev_word = {out_last, out_data};
            end
            if (!finished) begin
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!finished) $display("FAIL burst_timeout: no done within %0d cycles (base %h len %0d)", budget, b, l);
        else n_pass++;
        n_checks++;
        if (lc == 0) begin
            if (first_cen != -1 || first_valid != -1)
                $display("FAIL empty_burst: cen cycle %0d valid cycle %0d, expected neither", first_cen, first_valid);
            else n_pass++;
        end else if (first_cen != 1 || first_valid != 2) begin
            $display("FAIL first_latency: cen cycle %0d valid cycle %0d, expected 1 and 2", first_cen, first_valid);
        end else n_pass++;
        if (mode == 0 && lc > 0) begin
            n_checks++;
            if (last_hs != lc + 1) $display("FAIL throughput: last word cycle %0d expected %0d", last_hs, lc + 1);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL post_done: done %b busy %b valid %b, expected 0 0 0", done, busy, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        int acc, t, dones;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, sram_cen, sram_addr0, out_valid, out_last, out_data} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_idle: busy %b done %b cen %b addr %h valid %b last %b data %h", busy, done, sram_cen,
                     sram_addr0, out_valid, out_last, out_data);
        else n_pass++;
        n_checks++;
        if (sram_wea0 !== 4'b0000 || sram_wdata0 !== 32'h0)
            $display("FAIL write_tieoff: wea %h wdata %h expected 0 0", sram_wea0, sram_wdata0);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        base_addr = 8'h40; burst_len = 9'd8; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0; t = 0;
        while (acc < 3 && t < 40) begin
            if (out_valid === 1'b1) acc++;
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (acc != 3 || {busy, done, sram_cen, out_valid, out_last, out_data} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_mid_burst: words %0d busy %b done %b cen %b valid %b last %b data %h, expected 3 0 0 1 0 0 0",
                     acc, busy, done, sram_cen, out_valid, out_last, out_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || sram_cen === 1'b0 || out_valid === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0 || busy !== 1'b0) $display("FAIL reset_abandon: activity cycles %0d busy %b, expected 0 0", dones, busy);
        else n_pass++;
        run_burst(8'h40, 8, 2, 1'b0);
    endtask

    task automatic test_streaming();
        run_burst(8'h10, 4, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_burst(8'($urandom), 6, 1, 1'b0);
        run_burst(8'($urandom), 9, 2, 1'b0);
    endtask

    task automatic test_wrap();
        run_burst(8'hFE, 4, 0, 1'b0);
    endtask

    task automatic test_corner_lengths();
        run_burst(8'h33, 0, 0, 1'b0);
        run_burst(8'h80, 256, 2, 1'b0);
        run_burst(8'h05, 300, 0, 1'b0);
        run_burst(8'h70, 10, 2, 1'b1);
        run_burst(8'h71, 1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst(8'hA0, 3, 0, 1'b0);
        run_burst(8'hA3, 0, 0, 1'b0);
        run_burst(8'hA3, 5, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 14; n++) begin
            run_burst(8'($urandom), $urandom_range(0, 40), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef L1_RD_PERF_CNT_EN
    task automatic test_stall_cnt();
        int t;
        base_addr = 8'h20; burst_len = 9'd2; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        t = 0;
        while (done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (done !== 1'b1 || stall_cnt !== 16'd5) $display("FAIL stall_cnt: done %b count %0d expected 1 and 5", done, stall_cnt);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (stall_cnt !== 16'd5) $display("FAIL stall_cnt_hold: count %0d expected 5", stall_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_corner_lengths();
        test_back_to_back();
        test_random();
`ifdef L1_RD_PERF_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
